// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the serial frame transmitter
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    localparam logic [3:0] PREAMBLE      = 4'b1101;
    localparam int         DATA_W        = 8;
    // Line history (oldest..newest) that would complete a false preamble on the next bit.
    localparam logic [2:0] STUFF_TRIGGER = 3'b110;

endpackage

// File: rtl/seq_stuff_ctl.sv
// rtl/seq_stuff_ctl.sv - line-bit history and stuff decision
import seq_pkg::*;

module seq_stuff_ctl (
    input  logic clk,
    input  logic place,
    input  logic bit_val,
    input  logic clear,
    output logic stuff_next
);

    // hist[2] is the oldest bit, hist[0] the bit currently on the line.
    logic [2:0] hist;

    always_ff @(posedge clk) begin
        if (clear) begin
            hist <= 3'b000;
        end else if (place) begin
            hist <= {hist[1:0], bit_val};
        end
    end

    assign stuff_next = (hist == STUFF_TRIGGER);

endmodule

// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - preamble + bit-stuffed byte serializer with trailing gap
import seq_pkg::*;

module seq_frame_tx #(
    parameter int GAP_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              dout,
    output logic              frame_start,
    output logic              stuff,
    output logic              busy
);

    localparam logic [2:0] DATA_LAST = 3'(DATA_W - 1);
    localparam logic [2:0] GAP_LAST  = 3'(GAP_LEN);

    // State describes the bit currently on dout; the _n values form the next bit.
    tx_state_t         state, state_n;
    logic [1:0]        pre_idx, pre_idx_n;
    logic [2:0]        data_cnt, data_cnt_n;
    logic [2:0]        gap_cnt, gap_cnt_n;
    logic [DATA_W-1:0] data_sr, data_sr_n;
    logic              dout_n, frame_start_n, stuff_n;
    logic [1:0]        pre_sel;
    logic              stuff_next;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign pre_sel  = 2'd2 - pre_idx;

    always_comb begin
        state_n       = state;
        pre_idx_n     = pre_idx;
        data_cnt_n    = data_cnt;
        gap_cnt_n     = gap_cnt;
        data_sr_n     = data_sr;
        dout_n        = 1'b0;
        frame_start_n = 1'b0;
        stuff_n       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n       = PRE;
                    pre_idx_n     = 2'd0;
                    data_sr_n     = in_data;
                    dout_n        = PREAMBLE[3];
                    frame_start_n = 1'b1;
                end
            end
            PRE: begin
                if (pre_idx == 2'd3) begin
                    // Preamble tail 1,0,1 can never trigger a stuff, so the first data bit goes straight out.
                    state_n    = DATA;
                    data_cnt_n = 3'd0;
                    dout_n     = data_sr[DATA_W-1];
                    data_sr_n  = {data_sr[DATA_W-2:0], 1'b0};
                end else begin
                    pre_idx_n = pre_idx + 2'd1;
                    dout_n    = PREAMBLE[pre_sel];
                end
            end
            DATA: begin
                if (data_cnt == DATA_LAST) begin
                    state_n   = GAP;
                    gap_cnt_n = 3'd1;
                end else if (stuff_next) begin
                    stuff_n = 1'b1;
                end else begin
                    dout_n     = data_sr[DATA_W-1];
                    data_sr_n  = {data_sr[DATA_W-2:0], 1'b0};
                    data_cnt_n = data_cnt + 3'd1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n   = IDLE;
                    gap_cnt_n = 3'd0;
                end else begin
                    gap_cnt_n = gap_cnt + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pre_idx     <= 2'd0;
            data_cnt    <= 3'd0;
            gap_cnt     <= 3'd0;
            data_sr     <= '0;
            dout        <= 1'b0;
            frame_start <= 1'b0;
            stuff       <= 1'b0;
        end else begin
            state       <= state_n;
            pre_idx     <= pre_idx_n;
            data_cnt    <= data_cnt_n;
            gap_cnt     <= gap_cnt_n;
            data_sr     <= data_sr_n;
            dout        <= dout_n;
            frame_start <= frame_start_n;
            stuff       <= stuff_n;
        end
    end

    seq_stuff_ctl u_stuff_ctl (
        .clk        (clk),
        .place      (state_n != IDLE),
        .bit_val    (dout_n),
        .clear      (rst || (state_n == IDLE)),
        .stuff_next (stuff_next)
    );

endmodule

// File: tb/tb_seq_frame_tx.sv
// tb/tb_seq_frame_tx.sv - directed and random checks for seq_frame_tx
module tb_seq_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready, dout, frame_start, stuff, busy;

    int checks = 0;
    int errors = 0;

    seq_frame_tx #(.GAP_LEN(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .dout        (dout),
        .frame_start (frame_start),
        .stuff       (stuff),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Line monitor: overlapping 1101 detector plus an independent destuffing receiver.
    logic [3:0] det_win = 4'b0;
    logic [3:0] fs_hist = 4'b0;
    int         det_fires = 0, det_bad = 0, fs_cnt = 0, rx_stuff_err = 0;
    logic       rx_active = 1'b0;
    int         rx_pre = 0, rx_bits = 0;
    logic [2:0] rx_hist = 3'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        logic [3:0] w, f;
        w = {det_win[2:0], dout};
        f = {fs_hist[2:0], frame_start};
        det_win <= w;
        fs_hist <= f;
        if (w == 4'b1101) begin
            det_fires <= det_fires + 1;
            if (!f[3]) det_bad <= det_bad + 1;
        end
        if (frame_start) begin
            fs_cnt    <= fs_cnt + 1;
            rx_active <= 1'b1;
            rx_pre    <= 3;
            rx_bits   <= 0;
            rx_hist   <= {2'b00, dout};
        end else if (!busy) begin
            rx_active <= 1'b0;
        end else if (rx_active) begin
            rx_hist <= {rx_hist[1:0], dout};
            if (rx_pre > 0) begin
                rx_pre <= rx_pre - 1;
                if (stuff !== 1'b0) rx_stuff_err <= rx_stuff_err + 1;
            end else if (rx_bits < 8) begin
                if (rx_hist == 3'b110) begin
                    if (dout !== 1'b0 || stuff !== 1'b1) rx_stuff_err <= rx_stuff_err + 1;
                end else begin
                    if (stuff !== 1'b0) rx_stuff_err <= rx_stuff_err + 1;
                    rx_byte <= {rx_byte[6:0], dout};
                    rx_bits <= rx_bits + 1;
                    if (rx_bits == 7) rx_q.push_back({rx_byte[6:0], dout});
                end
            end else if (stuff !== 1'b0) begin
                rx_stuff_err <= rx_stuff_err + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one byte from IDLE and records dout/stuff/frame_start over the busy window.
    task automatic send_frame(input logic [7:0] b, output logic [31:0] bits,
                              output logic [31:0] sbits, output logic [31:0] fbits,
                              output int nbusy);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        exp_q.push_back(b);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        bits = 0; sbits = 0; fbits = 0; nbusy = 0;
        while (busy && nbusy < 40) begin
            bits  = {bits[30:0], dout};
            sbits = {sbits[30:0], stuff};
            fbits = {fbits[30:0], frame_start};
            nbusy++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] bits, sbits, fbits;
        int nbusy, n, det0, fs0, bad, gap;

        // Reset with a simultaneous offer: the byte must be ignored.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_stuff", stuff, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        in_valid = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_dout", dout, 0);

        send_frame(8'h00, bits, sbits, fbits, nbusy);
        chk("x00_bits", bits, 32'h3400);
        chk("x00_busy_cycles", nbusy, 14);
        chk("x00_stuff", sbits, 0);
        chk("x00_frame_start", fbits, 32'h2000);
        chk("x00_idle_ready", in_ready, 1);
        chk("x00_idle_dout", dout, 0);

        send_frame(8'hFF, bits, sbits, fbits, nbusy);
        chk("xff_bits", bits, 32'h37FC);
        chk("xff_busy_cycles", nbusy, 14);
        chk("xff_stuff", sbits, 0);

        send_frame(8'hB6, bits, sbits, fbits, nbusy);
        chk("xb6_bits", bits, 32'hD998);
        chk("xb6_busy_cycles", nbusy, 16);
        chk("xb6_stuff", sbits, 32'h0220);
        chk("xb6_frame_start", fbits, 32'h8000);

        // Back-to-back with in_valid held high.
        repeat (3) @(negedge clk);
        det0 = det_fires;
        in_valid = 1'b1; in_data = 8'hB6;
        exp_q.push_back(8'hB6);
        n = 0;
        while (!frame_start && n < 10) begin @(negedge clk); n++; end
        chk("b2b_first_start", frame_start, 1);
        in_data = 8'h6C;
        exp_q.push_back(8'h6C);
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_start && n < 40);
        chk("b2b_spacing", n, 17);
        in_valid = 1'b0;
        n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("b2b_detector_fires", det_fires - det0, 2);
        chk("b2b_detector_on_preamble", det_bad, 0);

        // Abort on the third DATA cycle (line bit is the first stuffed 0 of 0xB6).
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hB6;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_frame_start", frame_start, 1);
        repeat (6) @(negedge clk);
        chk("abort_third_data_stuff", stuff, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_dout", dout, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        chk("abort_no_restart", busy, 0);
        send_frame(8'h00, bits, sbits, fbits, nbusy);
        chk("post_abort_bits", bits, 32'h3400);
        chk("post_abort_busy_cycles", nbusy, 14);

        // Random stream with random offer gaps.
        repeat (2) @(negedge clk);
        det0 = det_fires;
        fs0  = fs_cnt;
        bad  = 0;
        for (int i = 0; i < 1000; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            n = 0;
            while (!in_ready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) bad++;
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(0, 255));
            exp_q.push_back(in_data);
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom_range(0, 255));
        end
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("rand_ready_timeouts", bad, 0);
        chk("rand_frames", fs_cnt - fs0, 1000);
        chk("rand_detector_fires", det_fires - det0, 1000);
        chk("detector_on_preamble_only", det_bad, 0);
        chk("stuff_placement", rx_stuff_err, 0);
        chk("payload_count", rx_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) bad++;
        end
        chk("payload_match", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 The block SHALL have parameter GAP_LEN, default 2, meaning the number of forced-0 gap bits after each payload, legal range 2..7.
REQ-002 The block SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1, a payload byte is offered.
REQ-005 The block SHALL have port in_data, input, 8, payload byte, transmitted MSB first.
REQ-006 The block SHALL have port in_ready, output, 1, the block can accept a byte this cycle.
REQ-007 The block SHALL have port dout, output, 1, serial line bit, one bit per clk.
REQ-008 The block SHALL have port frame_start, output, 1, high while the first preamble bit is on dout.
REQ-009 The block SHALL have port stuff, output, 1, high while a stuffed 0 is on dout.
REQ-010 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, PRE, DATA and GAP; dout, frame_start and stuff SHALL be registered, and in_ready and busy SHALL be decoded from state only, with no combinational path from in_valid.
REQ-012 In IDLE: in_ready=1 and dout=0; a byte SHALL be accepted on the edge where in_valid && in_ready, latched internally, and the state SHALL go to PRE.
REQ-013 PRE SHALL drive preamble 1,1,0,1 on four consecutive cycles, starting the cycle after acceptance; frame_start SHALL be 1 only on the first of these cycles.
REQ-014 DATA SHALL drive in_data[7] down to in_data[0], one bit per cycle, except where REQ-015 inserts a stuffed 0.
REQ-015 Stuffing: the block SHALL keep a 3-bit history of bits placed on dout, preamble and stuffed bits included; when in DATA, history (oldest to newest) = 1,1,0, and data bits remain, the next dout SHALL be a stuffed 0 with stuff=1, and no data bit is consumed.
REQ-016 No stuff SHALL be inserted after the eighth data bit; GAP follows immediately.
REQ-017 GAP SHALL drive dout=0 for GAP_LEN cycles, then the state SHALL return to IDLE.
REQ-018 in_ready SHALL be 0 in PRE, DATA and GAP; in_valid there SHALL be ignored and in_data need not be held.
REQ-019 Minimum spacing between frame_start pulses SHALL be 4 + 8 + k + GAP_LEN + 1 cycles, where k is the stuff count (0..2).
REQ-020 Invariant: pattern 1101 SHALL appear on dout only as the four preamble bits, including across frame boundaries.
REQ-021 The history register SHALL clear to 000 in IDLE.

Reset
REQ-022 On rst the block SHALL set state=IDLE, dout=0, frame_start=0, stuff=0, history=000, all counters 0; in_ready=1 and busy=0 on the following cycle.
REQ-023 rst mid-frame in any state SHALL abort the frame with no further preamble or data bits, and dout=0 from the next cycle.
REQ-024 rst SHALL take priority over a simultaneous in_valid; that byte SHALL NOT be accepted.

Structure
REQ-025 Package seq_pkg SHALL hold the tx_state_t enum (IDLE, PRE, DATA, GAP), the constant PREAMBLE=4'b1101, and DATA_W=8.
REQ-026 The history and stuff-decision logic SHALL be one sub-module, seq_stuff_ctl: inputs bit-placed/bit-value/clear, output stuff_next; the remainder is a single FSM with a 2-bit preamble index, 3-bit data count and 3-bit gap count.

Verification
REQ-027 The bench SHALL cover: send 0x00 -> dout 1101,00000000,00 then IDLE; 14 busy cycles; stuff never 1.
REQ-028 The bench SHALL cover: send 0xFF -> dout 1101,11111111,00; no stuffs.
REQ-029 The bench SHALL cover: send 0xB6 -> payload on dout 1,0,S,1,1,0,S,1,1,0 (S=stuffed 0); stuff=1 on payload cycles 3 and 7; 16 busy cycles.
REQ-030 The bench SHALL cover: back-to-back 0xB6, 0x6C with in_valid held high -> second frame_start exactly 17 cycles after the first; an overlapping 1101 detector model on dout fires exactly twice, on the fourth preamble bit of each frame.
REQ-031 The bench SHALL cover: rst asserted on the third DATA cycle -> next cycle dout=0, busy=0, in_ready=1; a new byte is then accepted normally.
REQ-032 The bench SHALL cover: 1000 random bytes streamed with random in_valid gaps -> the detector model fires once per frame, and the destuffed payload matches the input bytes.
